// File: rtl/timer_dev.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) with level interrupt.
// Optional prescaler on CTRL[7:4] is built only when TIMER_PRESCALE_EN is defined.
module timer_dev #(
    parameter int WIDTH    = 32,
    parameter int PRE_BITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

`ifdef TIMER_PRESCALE_EN
    localparam int CTRL_W = 8;
`else
    localparam int CTRL_W = 4;
`endif

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  preset_q, preset_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic              flag_q, flag_d;
    logic              wr_ctrl, wr_preset;
    logic              auto_mode;
    logic              en_clr;
    logic              tick;

    assign wr_ctrl   = sel & we & (addr == 2'd0);
    assign wr_preset = sel & we & (addr == 2'd1);
    assign auto_mode = (ctrl_q[2:1] == 2'b01);

`ifdef TIMER_PRESCALE_EN
    logic [PRE_BITS-1:0] ps_q, ps_d;
    assign tick = (ps_q == PRE_BITS'(ctrl_q[7:4]));
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        flag_d   = flag_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        en_clr   = 1'b0;
`ifdef TIMER_PRESCALE_EN
        ps_d     = ps_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ctrl_q[0]) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
`ifdef TIMER_PRESCALE_EN
                ps_d    = '0;
`endif
            end
            S_CNT: begin
                if (ctrl_q[0]) begin
`ifdef TIMER_PRESCALE_EN
                    ps_d = tick ? '0 : ps_q + PRE_BITS'(1);
`endif
                    // PRESET=0 lands here too and fires like PRESET=1
                    if (tick) begin
                        if (count_q <= WIDTH'(1)) begin
                            count_d = '0;
                            state_d = S_INT;
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
            end
            default: begin
                if (auto_mode) begin
                    state_d = S_LOAD;
                end else begin
                    en_clr  = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase

        if (state_q == S_INT)          flag_d = 1'b1;
        else if (wr_ctrl || auto_mode) flag_d = 1'b0;

        if (wr_ctrl)     ctrl_d    = wdata[CTRL_W-1:0];
        else if (en_clr) ctrl_d[0] = 1'b0;

        // A PRESET write parks the FSM in IDLE and leaves COUNT untouched
        if (wr_preset) begin
            preset_d = wdata;
            state_d  = S_IDLE;
            count_d  = count_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            flag_q   <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            ps_q     <= '0;
`endif
        end else begin
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            state_q  <= state_d;
            flag_q   <= flag_d;
`ifdef TIMER_PRESCALE_EN
            ps_q     <= ps_d;
`endif
        end
    end

    always_comb begin
        case (addr)
            2'd0:    rdata = WIDTH'(ctrl_q);
            2'd1:    rdata = preset_q;
            2'd2:    rdata = count_q;
            default: rdata = '0;
        endcase
    end

    assign irq = flag_q & ctrl_q[3];

endmodule
